// File: rtl/assoc_pkg.sv
// Shared definitions for the associative-buffer command sequencer.
// Holds the buffer ctrl encodings, the command opcodes, the sequencer FSM
// state type and small opcode classification helpers.
package assoc_pkg;

    // Buffer ctrl lane encodings
    localparam logic [1:0] CTRL_NONE = 2'd0;
    localparam logic [1:0] CTRL_CLR  = 2'd1;
    localparam logic [1:0] CTRL_LOAD = 2'd2;
    localparam logic [1:0] CTRL_INCR = 2'd3;

    // Command opcodes (5..7 are illegal)
    localparam logic [2:0] OP_READ       = 3'd0;
    localparam logic [2:0] OP_WRITE      = 3'd1;
    localparam logic [2:0] OP_INCR       = 3'd2;
    localparam logic [2:0] OP_CLEAR      = 3'd3;
    localparam logic [2:0] OP_FETCH_INCR = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    // Commands that return a value through the response slot
    function automatic logic op_has_resp(input logic [2:0] op);
        return (op == OP_READ) || (op == OP_FETCH_INCR);
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_FETCH_INCR;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head (rdata shows the oldest
// entry whenever empty=0) so the consumer can act on it in the same cycle.
// Ports: clk, rst (async, active-high), flush (discard all entries next edge,
// a push in the same cycle is dropped), push/wdata, pop/rdata, full, empty,
// count (number of stored entries, 0..DEPTH).
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rdata   = mem[rd_ptr_reg];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/assoc_cmd_sequencer.sv
// Upstream command stage for the associative buffer.
// Commands (cmd_*) are queued in a FIFO and issued one per cycle from the
// FIFO head onto buf_ctrl/buf_key/buf_data. READ and FETCH_INCR capture the
// buffer's combinational buf_data_output/buf_valid in their issue cycle and
// present them on the resp_* valid/ready port (one-entry slot).
// Ports: clk, rst (async, active-high), cmd_valid/cmd_ready/cmd_op/cmd_key/
// cmd_data, flush, buf_ctrl/buf_key/buf_data, buf_data_output/buf_valid,
// resp_valid/resp_ready/resp_data/resp_hit/resp_key, fifo_count, err (sticky).
module assoc_cmd_sequencer
    import assoc_pkg::*;
#(
    parameter int KEY_WIDTH  = 5,
    parameter int DATA_WIDTH = 8,
    parameter int CTRL_WIDTH = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [KEY_WIDTH-1:0]          cmd_key,
    input  logic [DATA_WIDTH-1:0]         cmd_data,
    input  logic                          flush,
    output logic [CTRL_WIDTH-1:0]         buf_ctrl,
    output logic [KEY_WIDTH-1:0]          buf_key,
    output logic [DATA_WIDTH-1:0]         buf_data,
    input  logic [DATA_WIDTH-1:0]         buf_data_output,
    input  logic                          buf_valid,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic                          resp_hit,
    output logic [KEY_WIDTH-1:0]          resp_key,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err
);
    localparam int EW    = 3 + KEY_WIDTH + DATA_WIDTH;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t                state_reg, state_next;
    logic [EW-1:0]         head;
    logic [2:0]            head_op;
    logic [KEY_WIDTH-1:0]  head_key;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  fifo_full, fifo_empty;
    logic                  push, fire, slot_free;
    logic [KEY_WIDTH-1:0]  last_key_reg;
    logic                  err_reg;
    logic                  resp_valid_reg, resp_hit_reg;
    logic [DATA_WIDTH-1:0] resp_data_reg;
    logic [KEY_WIDTH-1:0]  resp_key_reg;

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full && !flush;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata ({cmd_op, cmd_key, cmd_data}),
        .pop   (fire),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_op   = head[EW-1 -: 3];
    assign head_key  = head[DATA_WIDTH +: KEY_WIDTH];
    assign head_data = head[DATA_WIDTH-1:0];

    // The slot can be refilled in the same cycle its current entry is consumed
    assign slot_free = !resp_valid_reg || resp_ready;

    // Head is driven and popped only in ISSUE; a response command waits for the slot
    assign fire = (state_reg == ST_ISSUE) && !fifo_empty && !flush &&
                  (!op_has_resp(head_op) || slot_free);

    always_comb begin
        state_next = state_reg;
        buf_ctrl   = CTRL_WIDTH'(CTRL_NONE);
        buf_key    = last_key_reg;   // holding the old key avoids spurious allocation
        buf_data   = '0;

        if (fire && op_legal(head_op)) begin
            buf_key = head_key;
            case (head_op)
                OP_WRITE: begin
                    buf_ctrl = CTRL_WIDTH'(CTRL_LOAD);
                    buf_data = head_data;
                end
                OP_INCR, OP_FETCH_INCR: buf_ctrl = CTRL_WIDTH'(CTRL_INCR);
                OP_CLEAR:               buf_ctrl = CTRL_WIDTH'(CTRL_CLR);
                default:                buf_ctrl = CTRL_WIDTH'(CTRL_NONE);
            endcase
        end

        case (state_reg)
            ST_IDLE: begin
                // Looking at the incoming push gives single-cycle issue latency
                if (!flush && (push || !fifo_empty)) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (fire) begin
                    state_next = (push || (fifo_count > CNT_W'(1))) ? ST_ISSUE : ST_IDLE;
                end else if (!fifo_empty) begin
                    state_next = ST_STALL;
                end else begin
                    state_next = push ? ST_ISSUE : ST_IDLE;
                end
            end
            ST_STALL: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (slot_free) begin
                    state_next = ST_ISSUE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            last_key_reg   <= '0;
            err_reg        <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
            resp_hit_reg   <= 1'b0;
            resp_key_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (fire) begin
                if (op_legal(head_op)) begin
                    last_key_reg <= head_key;
                end else begin
                    err_reg <= 1'b1;
                end
            end
            if (fire && op_has_resp(head_op)) begin
                resp_valid_reg <= 1'b1;
                resp_data_reg  <= buf_data_output;
                resp_hit_reg   <= buf_valid;
                resp_key_reg   <= head_key;
            end else if (resp_ready) begin
                resp_valid_reg <= 1'b0;
            end
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
    assign resp_hit   = resp_hit_reg;
    assign resp_key   = resp_key_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_assoc_cmd_sequencer.sv
module tb_assoc_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [4:0] cmd_key = 5'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       flush = 1'b0;
    logic [1:0] buf_ctrl;
    logic [4:0] buf_key;
    logic [7:0] buf_data;
    logic [7:0] buf_data_output;
    logic       buf_valid;
    logic       resp_valid;
    logic       resp_ready = 1'b1;
    logic [7:0] resp_data;
    logic       resp_hit;
    logic [4:0] resp_key;
    logic [2:0] fifo_count;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       hit;
        logic [4:0] key;
    } resp_t;
    resp_t resp_q[$];

    always #5 clk = ~clk;

    assoc_cmd_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_key         (cmd_key),
        .cmd_data        (cmd_data),
        .flush           (flush),
        .buf_ctrl        (buf_ctrl),
        .buf_key         (buf_key),
        .buf_data        (buf_data),
        .buf_data_output (buf_data_output),
        .buf_valid       (buf_valid),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_hit        (resp_hit),
        .resp_key        (resp_key),
        .fifo_count      (fifo_count),
        .err             (err)
    );

    // Behavioural associative buffer: combinational lookup, any presented key allocates
    logic [7:0] bmem  [32];
    logic       bpres [32];
    assign buf_data_output = bmem[buf_key];
    assign buf_valid       = bpres[buf_key];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                bmem[i]  <= 8'd0;
                bpres[i] <= 1'b0;
            end
        end else begin
            case (buf_ctrl)
                2'd0: bpres[buf_key] <= 1'b1;
                2'd1: begin bpres[buf_key] <= 1'b0; bmem[buf_key] <= 8'd0; end
                2'd2: begin bpres[buf_key] <= 1'b1; bmem[buf_key] <= buf_data; end
                default: begin bpres[buf_key] <= 1'b1; bmem[buf_key] <= bmem[buf_key] + 8'd1; end
            endcase
        end
    end

    // Response monitor: records every handshake
    always @(posedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            resp_q.push_back('{data: resp_data, hit: resp_hit, key: resp_key});
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [4:0] key, input logic [7:0] data);
        cmd_op    = op;
        cmd_key   = key;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [7:0] d, input logic h, input logic [4:0] k);
        resp_t r;
        int    t = 0;
        while (resp_q.size() == 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (resp_q.size() == 0) begin
            check_val({tag, "_present"}, resp_q.size(), 1);
        end else begin
            r = resp_q.pop_front();
            check_val({tag, "_data"}, r.data, d);
            check_val({tag, "_hit"},  r.hit,  h);
            check_val({tag, "_key"},  r.key,  k);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_cmd_ready",  cmd_ready,  1);
        check_val("rst_resp_valid", resp_valid, 0);
        check_val("rst_count",      fifo_count, 0);
        check_val("rst_buf_ctrl",   buf_ctrl,   0);
        check_val("rst_buf_key",    buf_key,    0);
        check_val("rst_err",        err,        0);
        rst = 1'b0;
        @(negedge clk);

        // WRITE k5 0x3C then READ k5
        push_cmd(3'd1, 5'd5, 8'h3C);
        check_val("wr_ctrl", buf_ctrl, 2);
        check_val("wr_key",  buf_key,  5);
        check_val("wr_data", buf_data, 8'h3C);
        push_cmd(3'd0, 5'd5, 8'h00);
        check_val("rd_ctrl", buf_ctrl, 0);
        check_val("rd_data", buf_data, 0);
        @(negedge clk);
        check_val("rd_resp_valid", resp_valid, 1);
        expect_resp("rd5", 8'h3C, 1'b1, 5'd5);

        // FETCH_INCR twice then READ, queued behind a blocked slot
        resp_ready = 1'b0;
        push_cmd(3'd4, 5'd5, 8'h00);
        push_cmd(3'd4, 5'd5, 8'h00);
        push_cmd(3'd0, 5'd5, 8'h00);
        resp_ready = 1'b1;
        expect_resp("fi1", 8'h3C, 1'b1, 5'd5);
        expect_resp("fi2", 8'h3D, 1'b1, 5'd5);
        expect_resp("fi_rd", 8'h3E, 1'b1, 5'd5);

        // Miss then hit on k9
        push_cmd(3'd0, 5'd9, 8'h00);
        push_cmd(3'd0, 5'd9, 8'h00);
        expect_resp("miss9", 8'h00, 1'b0, 5'd9);
        expect_resp("hit9",  8'h00, 1'b1, 5'd9);
        repeat (3) @(negedge clk);

        // Stall: READ, INCR, READ with resp_ready low
        resp_ready = 1'b0;
        push_cmd(3'd0, 5'd5, 8'h00);
        push_cmd(3'd2, 5'd5, 8'h00);
        check_val("st_incr_ctrl", buf_ctrl, 3);
        push_cmd(3'd0, 5'd5, 8'h00);
        repeat (2) @(negedge clk);
        check_val("st_ctrl",       buf_ctrl,   0);
        check_val("st_key",        buf_key,    5);
        check_val("st_resp_valid", resp_valid, 1);
        check_val("st_resp_data",  resp_data,  8'h3E);
        check_val("st_count",      fifo_count, 1);
        resp_ready = 1'b1;
        expect_resp("st_r1", 8'h3E, 1'b1, 5'd5);
        expect_resp("st_r2", 8'h3F, 1'b1, 5'd5);
        repeat (3) @(negedge clk);

        // Fill FIFO behind a blocked response, then flush
        resp_ready = 1'b0;
        push_cmd(3'd0, 5'd5, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            push_cmd(3'd0, 5'(i), 8'h00);
        end
        check_val("full_ready", cmd_ready,  0);
        check_val("full_count", fifo_count, 4);
        push_cmd(3'd0, 5'd7, 8'h00);
        check_val("full_count_hold", fifo_count, 4);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_val("fl_count",      fifo_count, 0);
        check_val("fl_ready",      cmd_ready,  1);
        check_val("fl_resp_valid", resp_valid, 1);
        check_val("fl_resp_data",  resp_data,  8'h3F);
        check_val("fl_resp_key",   resp_key,   5);
        check_val("fl_ctrl",       buf_ctrl,   0);
        resp_ready = 1'b1;
        expect_resp("fl_r", 8'h3F, 1'b1, 5'd5);
        repeat (4) @(negedge clk);
        check_val("fl_no_more_resp", resp_q.size(), 0);

        // Illegal opcode, then CLEAR
        push_cmd(3'd6, 5'd3, 8'h00);
        check_val("ill_ctrl",    buf_ctrl, 0);
        check_val("ill_err_pre", err,      0);
        push_cmd(3'd3, 5'd9, 8'h00);
        check_val("clr_ctrl", buf_ctrl, 1);
        check_val("clr_key",  buf_key,  9);
        check_val("ill_err",  err,      1);
        repeat (3) @(negedge clk);
        check_val("ill_no_resp", resp_q.size(), 0);
        check_val("ill_resp_valid", resp_valid, 0);
        check_val("ill_err_sticky", err, 1);

        // Async reset in the middle of a stall
        resp_ready = 1'b0;
        push_cmd(3'd0, 5'd5, 8'h00);
        push_cmd(3'd0, 5'd5, 8'h00);
        repeat (2) @(negedge clk);
        check_val("ar_pre_valid", resp_valid, 1);
        check_val("ar_pre_count", fifo_count, 1);
        rst = 1'b1;
        #1;
        check_val("ar_resp_valid", resp_valid, 0);
        check_val("ar_ready",      cmd_ready,  1);
        check_val("ar_count",      fifo_count, 0);
        check_val("ar_err",        err,        0);
        check_val("ar_ctrl",       buf_ctrl,   0);
        @(negedge clk);
        rst = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
